fetch_queue_unit: RTL and testbench
===================================

// Module: fetch_queue_unit
// PURPOSE
//  Parametrised instruction-fetch front end with a DEPTH-entry IF/ID queue. Sits between the
//  instruction cache and the control unit / register file. Generates fetch PCs, absorbs icache
//  misses through a small FSM, buffers {PC, instruction} pairs, and flushes on branch/jump redirect.
//  Replaces the PC register, the +4 adder and the single IF/ID register with one stall-aware block.
// PARAMETERS
//  DEPTH     4             queue entries, >=2; COUNT width is $clog2(DEPTH+1)
//  RESET_PC  32'h00000000  first fetch address after reset
//  NOP_INSTR 32'h00000013  instruction (addi x0,x0,0) driven on INSTRUCTION when queue empty
// PORTS
//  CLK            in   1   clock; all state updates on posedge
//  RESET          in   1   asynchronous, active-high reset
//  FETCH_PC       out  32  address presented to icache
//  FETCH_REQ      out  1   icache read request
//  ICACHE_INSTR   in   32  icache read data, valid when FETCH_REQ=1 and ICACHE_BUSYWAIT=0
//  ICACHE_BUSYWAIT in  1   icache miss in progress; data not valid
//  REDIRECT       in   1   taken branch/jump from EX (PC_MUX_CONTROL)
//  REDIRECT_ADDR  in   32  target address; bits [1:0] ignored (treated as 00)
//  STALL          in   1   decode cannot accept (data-cache BUSYWAIT / hazard)
//  VALID_OUT      out  1   queue head is a real instruction
//  INSTRUCTION    out  32  queue head instruction, NOP_INSTR when VALID_OUT=0
//  PC_OUT         out  32  PC of queue head (0 when empty)
//  PC_PLUS_4_OUT  out  32  PC_OUT + 4, wraps modulo 2^32
//  COUNT          out  $clog2(DEPTH+1)  occupied entries
// BEHAVIOUR
//  Reset (async, any state): FSM=RUN, fetch_pc=RESET_PC, COUNT=0, pointers=0, VALID_OUT=0,
//   INSTRUCTION=NOP_INSTR, PC_OUT=0, PC_PLUS_4_OUT=4, FETCH_REQ=1, FETCH_PC=RESET_PC.
//  Queue: circular buffer, head/tail wrap modulo DEPTH. Outputs driven combinationally from head.
//  pop  = VALID_OUT & ~STALL & ~REDIRECT.
//  space = (COUNT<DEPTH) | pop  (full queue may push in the same cycle it pops).
//  push = FSM in RUN/MISS & FETCH_REQ & ~ICACHE_BUSYWAIT & space & ~REDIRECT.
//  On push: entry <= {fetch_pc, ICACHE_INSTR}; fetch_pc <= fetch_pc+4 (mod 2^32). Latency: instr
//   fetched at posedge N is visible on INSTRUCTION after posedge N (one-cycle queue latency).
//  COUNT <= COUNT + push - pop; never exceeds DEPTH, never underflows.
//  FETCH_REQ = 1 in MISS and DRAIN; in RUN = space. FETCH_PC = fetch_pc (RUN/MISS), held_pc (DRAIN).
//  FSM:
//   RUN  : FETCH_REQ & ICACHE_BUSYWAIT -> MISS (address held). REDIRECT -> flush, fetch_pc<=target.
//   MISS : address held stable until BUSYWAIT falls; then push if space, -> RUN.
//          If no space when data returns, data not pushed, address unchanged, -> RUN (refetch).
//          REDIRECT in MISS -> flush, held_pc<=fetch_pc, pending_pc<=target, -> DRAIN.
//   DRAIN: hold held_pc until ICACHE_BUSYWAIT=0; returned data discarded; fetch_pc<=pending_pc,
//          -> RUN. Further REDIRECT in DRAIN overwrites pending_pc only.
//  REDIRECT (any state, posedge): COUNT<=0, head=tail=0, no push, no pop; highest priority
//   over STALL, push and pop. VALID_OUT=0 the following cycle; first target instr visible after
//   the first hit fetch in RUN (2 cycles after redirect on icache hit).
//  STALL with queue non-empty: head outputs held unchanged; fetching continues until full.
//  Empty queue with STALL=0: VALID_OUT=0, NOP_INSTR issued (bubble), no pop.
// TESTING
//  1 Reset, icache always hits, STALL=0: PC_OUT sequence 0,4,8,... from 2nd cycle; COUNT stays <=1.
//  2 STALL=1 for 10 cycles, DEPTH=4: COUNT saturates at 4, FETCH_REQ=0, FETCH_PC=0x10; release ->
//    INSTRUCTION order 0x0,0x4,0x8,0xC,0x10 with no gaps or duplicates.
//  3 REDIRECT=1, REDIRECT_ADDR=0x103 with COUNT=3: next cycle COUNT=0, VALID_OUT=0, INSTRUCTION=
//    0x00000013; following cycle PC_OUT=0x100.
//  4 BUSYWAIT 5 cycles at PC 0x20, REDIRECT to 0x80 on cycle 2: FETCH_PC stays 0x20 until BUSYWAIT=0,
//    data at 0x20 never appears; next fetch and next valid PC_OUT=0x80.
//  5 fetch_pc=0xFFFFFFFC: PC_PLUS_4_OUT=0x00000000, next FETCH_PC=0x00000000.
//  6 RESET asserted mid-miss with COUNT=2: outputs reach reset values immediately (no CLK edge).

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: PC generation, icache miss handling and a DEPTH-entry
// circular IF/ID queue of {PC, instruction} pairs that is flushed on redirect.
module fetch_queue_unit #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  localparam int         CW        = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RESET,
  output logic [31:0]   FETCH_PC,
  output logic          FETCH_REQ,
  input  logic [31:0]   ICACHE_INSTR,
  input  logic          ICACHE_BUSYWAIT,
  input  logic          REDIRECT,
  input  logic [31:0]   REDIRECT_ADDR,
  input  logic          STALL,
  output logic          VALID_OUT,
  output logic [31:0]   INSTRUCTION,
  output logic [31:0]   PC_OUT,
  output logic [31:0]   PC_PLUS_4_OUT,
  output logic [CW-1:0] COUNT
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {RUN, MISS, DRAIN} state_t;

  state_t        state, state_next;
  logic [31:0]   fetch_pc, fetch_pc_next;
  logic [31:0]   held_pc, held_pc_next;
  logic [31:0]   pending_pc, pending_pc_next;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          valid, pop, push, space;
  logic [31:0]   target;
  logic          unused_addr_bits;

  assign target           = {REDIRECT_ADDR[31:2], 2'b00};
  assign unused_addr_bits = ^REDIRECT_ADDR[1:0];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full queue still has space when its head leaves this cycle.
  always_comb begin
    valid         = (count != '0);
    pop           = valid & ~STALL & ~REDIRECT;
    space         = (count < CW'(DEPTH)) | pop;
    FETCH_REQ     = (state == RUN) ? space : 1'b1;
    FETCH_PC      = (state == DRAIN) ? held_pc : fetch_pc;
    push          = (state != DRAIN) & FETCH_REQ & ~ICACHE_BUSYWAIT & space & ~REDIRECT;
    VALID_OUT     = valid;
    INSTRUCTION   = valid ? instr_mem[head] : NOP_INSTR;
    PC_OUT        = valid ? pc_mem[head] : 32'h0;
    PC_PLUS_4_OUT = PC_OUT + 32'd4;
    COUNT         = count;
  end

  // A redirect during a miss must keep the missed address on the bus until the
  // icache finishes, so the new target waits in pending_pc.
  always_comb begin
    state_next      = state;
    fetch_pc_next   = fetch_pc;
    held_pc_next    = held_pc;
    pending_pc_next = pending_pc;
    case (state)
      RUN: begin
        if (REDIRECT)
          fetch_pc_next = target;
        else if (FETCH_REQ && ICACHE_BUSYWAIT)
          state_next = MISS;
        else if (push)
          fetch_pc_next = fetch_pc + 32'd4;
      end
      MISS: begin
        if (REDIRECT) begin
          state_next      = DRAIN;
          held_pc_next    = fetch_pc;
          pending_pc_next = target;
        end else if (!ICACHE_BUSYWAIT) begin
          state_next = RUN;
          if (push)
            fetch_pc_next = fetch_pc + 32'd4;
        end
      end
      DRAIN: begin
        if (REDIRECT)
          pending_pc_next = target;
        if (!ICACHE_BUSYWAIT) begin
          state_next    = RUN;
          fetch_pc_next = REDIRECT ? target : pending_pc;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= RUN;
      fetch_pc   <= RESET_PC;
      held_pc    <= RESET_PC;
      pending_pc <= RESET_PC;
    end else begin
      state      <= state_next;
      fetch_pc   <= fetch_pc_next;
      held_pc    <= held_pc_next;
      pending_pc <= pending_pc_next;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (REDIRECT) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)
        tail <= ptr_inc(tail);
      if (pop)
        head <= ptr_inc(head);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: entries are only read while COUNT says they are valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      pc_mem[tail]    <= fetch_pc;
      instr_mem[tail] <= ICACHE_INSTR;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: behavioural icache, PC-order scoreboard
// and directed checks for stall, redirect, miss/drain, PC wrap and async reset.
module tb_fetch_queue_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_pc;
  logic        fetch_req;
  logic [31:0] icache_instr;
  logic        busy;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        stall;
  logic        valid_out;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic [31:0] pc_plus_4;
  logic [2:0]  count;

  int          vectors = 0;
  int          miscompares = 0;
  int          pops = 0;
  logic [31:0] sb [$];

  fetch_queue_unit #(.DEPTH(4), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .CLK(clk), .RESET(reset), .FETCH_PC(fetch_pc), .FETCH_REQ(fetch_req),
    .ICACHE_INSTR(icache_instr), .ICACHE_BUSYWAIT(busy), .REDIRECT(redirect),
    .REDIRECT_ADDR(redirect_addr), .STALL(stall), .VALID_OUT(valid_out),
    .INSTRUCTION(instruction), .PC_OUT(pc_out), .PC_PLUS_4_OUT(pc_plus_4), .COUNT(count)
  );

  always #5 clk = ~clk;

  // Icache content is a fixed function of the address so any slip in PC/data pairing shows up.
  function automatic logic [31:0] mk(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0001;
  endfunction

  assign icache_instr = mk(fetch_pc);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_sb(input logic [31:0] start);
    logic [31:0] pc;
    sb.delete();
    pc = start;
    for (int i = 0; i < 64; i++) begin
      sb.push_back(pc);
      pc = pc + 32'd4;
    end
  endtask

  // Drive one cycle of inputs; if the head is consumed this cycle it must match the scoreboard.
  task automatic applyStimulus(input logic s, input logic r, input logic [31:0] a, input logic b);
    logic [31:0] exp;
    stall = s; redirect = r; redirect_addr = a; busy = b;
    #1;
    if (valid_out && !s && !r) begin
      pops++;
      if (sb.size() == 0) begin
        checkOutput("sb_underrun", {31'b0, valid_out}, 32'h0);
      end else begin
        exp = sb.pop_front();
        checkOutput("sb_pc", pc_out, exp);
        checkOutput("sb_instr", instruction, mk(exp));
        checkOutput("sb_pc4", pc_plus_4, exp + 32'd4);
      end
    end else if (!valid_out) begin
      checkOutput("bubble_instr", instruction, NOP);
    end
    if (r) load_sb({a[31:2], 2'b00});
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    stall = 1'b0; redirect = 1'b0; redirect_addr = 32'h0; busy = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    load_sb(32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_valid"}, {31'b0, valid_out}, 32'h0);
    checkOutput({tag, "_instr"}, instruction, NOP);
    checkOutput({tag, "_pc"}, pc_out, 32'h0);
    checkOutput({tag, "_pc4"}, pc_plus_4, 32'h4);
    checkOutput({tag, "_req"}, {31'b0, fetch_req}, 32'h1);
    checkOutput({tag, "_fpc"}, fetch_pc, 32'h0);
    checkOutput({tag, "_count"}, 32'(count), 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0; redirect = 1'b0; redirect_addr = 32'h0; busy = 1'b0;
    #12;
    check_reset_outputs("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    load_sb(32'h0);

    // Steady hits, no stall: one entry in flight, PCs 0,4,8,...
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("t1_count_le1", {31'b0, (count > 3'd1)}, 32'h0);
    end
    checkOutput("t1_pops", pops, 7);

    // Stall fills the queue, then drains in order while refilling.
    apply_reset();
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("t2_count", 32'(count), 32'd4);
    checkOutput("t2_req", {31'b0, fetch_req}, 32'h0);
    checkOutput("t2_fpc", fetch_pc, 32'h10);
    checkOutput("t2_head", instruction, mk(32'h0));
    pops = 0;
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t2_pops", pops, 6);
    checkOutput("t2_count_full", 32'(count), 32'd4);

    // Redirect with three entries queued flushes everything.
    apply_reset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("t3_count_pre", 32'(count), 32'd3);
    applyStimulus(1'b0, 1'b1, 32'h103, 1'b0);
    checkOutput("t3_count", 32'(count), 32'd0);
    checkOutput("t3_valid", {31'b0, valid_out}, 32'h0);
    checkOutput("t3_instr", instruction, NOP);
    checkOutput("t3_fpc", fetch_pc, 32'h100);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t3_pc", pc_out, 32'h100);
    checkOutput("t3_valid2", {31'b0, valid_out}, 32'h1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);

    // Miss at 0x20, redirect to 0x80 while the miss is outstanding.
    apply_reset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t4_fpc_pre", fetch_pc, 32'h20);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t4_fpc1", fetch_pc, 32'h20);
    checkOutput("t4_count1", 32'(count), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h80, 1'b1);
    checkOutput("t4_fpc2", fetch_pc, 32'h20);
    checkOutput("t4_valid2", {31'b0, valid_out}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("t4_hold", fetch_pc, 32'h20);
      checkOutput("t4_req", {31'b0, fetch_req}, 32'h1);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t4_fpc_tgt", fetch_pc, 32'h80);
    checkOutput("t4_valid_drop", {31'b0, valid_out}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t4_pc", pc_out, 32'h80);
    checkOutput("t4_valid", {31'b0, valid_out}, 32'h1);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);

    // PC wrap at the top of the address space; low target bits ignored.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    checkOutput("t5_fpc", fetch_pc, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t5_pc", pc_out, 32'hFFFF_FFFC);
    checkOutput("t5_pc4", pc_plus_4, 32'h0);
    checkOutput("t5_fpc_wrap", fetch_pc, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t5_pc_next", pc_out, 32'h0);

    // Asynchronous reset in the middle of a miss with two entries queued.
    apply_reset();
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("t6_count_pre", 32'(count), 32'd2);
    checkOutput("t6_fpc_pre", fetch_pc, 32'h8);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("t6");
    @(posedge clk); #1;
    reset = 1'b0;
    stall = 1'b0; busy = 1'b0;
    load_sb(32'h0);
    pops = 0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t6_pops", pops, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
